// File: rtl/io_tile_param_if.sv
// Configuration scan and pad/interconnect data signals of one parametrised IO tile.
interface io_tile_param_if #(
  parameter int IO_PAIRS = 4,
  parameter int IC_WIDTH = 6
);
  logic                config_in;
  logic                config_enable;
  logic                config_out;
  logic                config_commit;
  logic                config_loaded;
  logic                configured;
  logic                enable;
  logic [IO_PAIRS-1:0] data_from_io;
  logic [IO_PAIRS-1:0] data_to_io;
  logic [IC_WIDTH-1:0] data_from_ic;
  logic [IC_WIDTH-1:0] data_to_ic;

  modport master (
    output config_in, config_enable, config_commit, enable, data_from_io, data_from_ic,
    input  config_out, config_loaded, configured, data_to_io, data_to_ic
  );

  modport slave (
    input  config_in, config_enable, config_commit, enable, data_from_io, data_from_ic,
    output config_out, config_loaded, configured, data_to_io, data_to_ic
  );
endinterface

// File: rtl/io_tile_param.sv
// Parametrised IO tile: serially loaded shadow configuration, atomically committed into an
// active configuration that drives per-pad and per-channel source muxes with optional registers.
module io_tile_param #(
  parameter int IO_PAIRS = 4,
  parameter int IC_WIDTH = 6
) (
  input logic           clock,
  input logic           reset,
  io_tile_param_if.slave bus
);
  localparam int SW_IC        = $clog2(IC_WIDTH);
  localparam int SW_IO        = $clog2(IO_PAIRS);
  localparam int PAD_F        = SW_IC + 1;
  localparam int CH_F         = SW_IO + 1;
  localparam int CH_BASE      = IO_PAIRS * PAD_F;
  localparam int CONFIG_WIDTH = IO_PAIRS * PAD_F + IC_WIDTH * CH_F;
  localparam int CNT_W        = $clog2(CONFIG_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CONFIG_WIDTH);

  logic [CONFIG_WIDTH-1:0] shadow;
  logic [CONFIG_WIDTH-1:0] active;
  logic [CNT_W-1:0]        count;
  logic                    configured_q;
  logic                    full;
  logic                    commit_ok;

  logic [IO_PAIRS-1:0] pad_raw;
  logic [IO_PAIRS-1:0] pad_q;
  logic [IO_PAIRS-1:0] pad_reg_sel;
  logic [IC_WIDTH-1:0] ch_raw;
  logic [IC_WIDTH-1:0] ch_q;
  logic [IC_WIDTH-1:0] ch_reg_sel;

  assign full      = (count == FULL_COUNT);
  assign commit_ok = bus.config_commit && full;

  // A commit captures the pre-shift shadow; a concurrent shift starts the next frame at count 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow       <= '0;
      active       <= '0;
      count        <= '0;
      configured_q <= 1'b0;
    end else begin
      if (bus.config_enable) shadow <= {shadow[CONFIG_WIDTH-2:0], bus.config_in};
      if (commit_ok) begin
        active       <= shadow;
        configured_q <= 1'b1;
        count        <= bus.config_enable ? CNT_W'(1) : '0;
      end else if (bus.config_enable && !full) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Selects beyond the last source match no loop index, so they read as 0.
  always_comb begin
    pad_raw     = '0;
    pad_reg_sel = '0;
    for (int unsigned p = 0; p < IO_PAIRS; p++) begin
      pad_reg_sel[p] = active[p*PAD_F + SW_IC];
      for (int unsigned c = 0; c < IC_WIDTH; c++) begin
        if (active[p*PAD_F +: SW_IC] == c[SW_IC-1:0]) pad_raw[p] = bus.data_from_ic[c];
      end
    end
  end

  always_comb begin
    ch_raw     = '0;
    ch_reg_sel = '0;
    for (int unsigned c = 0; c < IC_WIDTH; c++) begin
      ch_reg_sel[c] = active[CH_BASE + c*CH_F + SW_IO];
      for (int unsigned p = 0; p < IO_PAIRS; p++) begin
        if (active[CH_BASE + c*CH_F +: SW_IO] == p[SW_IO-1:0]) ch_raw[c] = bus.data_from_io[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || commit_ok) begin
      pad_q <= '0;
      ch_q  <= '0;
    end else if (bus.enable) begin
      pad_q <= pad_raw;
      ch_q  <= ch_raw;
    end
  end

  assign bus.config_out    = shadow[CONFIG_WIDTH-1];
  assign bus.config_loaded = full;
  assign bus.configured    = configured_q;
  assign bus.data_to_io    = configured_q ? ((pad_reg_sel & pad_q) | (~pad_reg_sel & pad_raw)) : '0;
  assign bus.data_to_ic    = configured_q ? ((ch_reg_sel & ch_q) | (~ch_reg_sel & ch_raw)) : '0;
endmodule

// File: tb/tb_io_tile_param.sv
// Directed bench for io_tile_param: two chained default tiles plus one IO_PAIRS=3 build.
module tb_io_tile_param;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  io_tile_param_if #(.IO_PAIRS(4), .IC_WIDTH(6)) ia ();
  io_tile_param_if #(.IO_PAIRS(4), .IC_WIDTH(6)) ib ();
  io_tile_param_if #(.IO_PAIRS(3), .IC_WIDTH(6)) i3 ();

  io_tile_param #(.IO_PAIRS(4), .IC_WIDTH(6)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  io_tile_param #(.IO_PAIRS(4), .IC_WIDTH(6)) dut_b (.clock(clock), .reset(reset), .bus(ib));
  io_tile_param #(.IO_PAIRS(3), .IC_WIDTH(6)) dut_c (.clock(clock), .reset(reset), .bus(i3));

  // Tile b sits downstream of tile a on the scan chain and shares its datapath inputs.
  assign ib.config_in     = ia.config_out;
  assign ib.config_enable = ia.config_enable;
  assign ib.enable        = ia.enable;
  assign ib.data_from_io  = ia.data_from_io;
  assign ib.data_from_ic  = ia.data_from_ic;

  typedef struct {
    logic [3:0] io;
    logic [5:0] icv;
    logic [3:0] exp_io;
    logic [5:0] exp_ic;
  } vec_t;

  vec_t vt[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [33:0] fa, fb, fc;
  logic [29:0] fd;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic shift_a(input logic [33:0] f, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      ia.config_in     = f[hi-i];
      ia.config_enable = 1'b1;
      step();
    end
    ia.config_enable = 1'b0;
    ia.config_in     = 1'b0;
  endtask

  task automatic shift_c(input logic [29:0] f);
    for (int i = 0; i < 30; i++) begin
      i3.config_in     = f[29-i];
      i3.config_enable = 1'b1;
      step();
    end
    i3.config_enable = 1'b0;
    i3.config_in     = 1'b0;
  endtask

  task automatic commit_a();
    ia.config_commit = 1'b1;
    step();
    ia.config_commit = 1'b0;
  endtask

  task automatic apply_vectors(input string tag);
    for (int i = 0; i < 7; i++) begin
      ia.data_from_io = vt[i].io;
      ia.data_from_ic = vt[i].icv;
      #1;
      check({tag, "_to_io"}, 64'(ia.data_to_io), 64'(vt[i].exp_io));
      check({tag, "_to_ic"}, 64'(ia.data_to_ic), 64'(vt[i].exp_ic));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Frame a: pad0 OSEL=2 comb, ch5 ISEL=3 comb, others select source 0 comb.
    vt[0] = '{io: 4'b0000, icv: 6'b000000, exp_io: 4'b0000, exp_ic: 6'b000000};
    vt[1] = '{io: 4'b1000, icv: 6'b000100, exp_io: 4'b0001, exp_ic: 6'b100000};
    vt[2] = '{io: 4'b0001, icv: 6'b000001, exp_io: 4'b1110, exp_ic: 6'b011111};
    vt[3] = '{io: 4'b1111, icv: 6'b111111, exp_io: 4'b1111, exp_ic: 6'b111111};
    vt[4] = '{io: 4'b0110, icv: 6'b111010, exp_io: 4'b0000, exp_ic: 6'b000000};
    vt[5] = '{io: 4'b1001, icv: 6'b000101, exp_io: 4'b1111, exp_ic: 6'b111111};
    vt[6] = '{io: 4'b1000, icv: 6'b000001, exp_io: 4'b1110, exp_ic: 6'b100000};

    fa = '0; fa[2:0] = 3'd2; fa[32:31] = 2'b11;
    fb = '0; fb[7:4] = 4'b1101; fb[11:8] = 4'b0111;
    fc = '0; fc[2:0] = 3'd5; fc[23:22] = 2'b11; fc[33:31] = 3'b101;
    fd = '0; fd[2:0] = 3'b111; fd[13:12] = 2'b11; fd[16:15] = 2'b10;

    ia.config_in = 0; ia.config_enable = 0; ia.config_commit = 0; ia.enable = 1;
    ia.data_from_io = '0; ia.data_from_ic = '0; ib.config_commit = 0;
    i3.config_in = 0; i3.config_enable = 0; i3.config_commit = 0; i3.enable = 1;
    i3.data_from_io = '0; i3.data_from_ic = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    check("rst_config_out", 64'(ia.config_out), 64'(0));
    check("rst_loaded", 64'(ia.config_loaded), 64'(0));
    check("rst_configured", 64'(ia.configured), 64'(0));
    check("rst_to_io", 64'(ia.data_to_io), 64'(0));
    check("rst_to_ic", 64'(ia.data_to_ic), 64'(0));

    for (int i = 0; i < 10; i++) begin
      ia.data_from_io  = 4'($urandom);
      ia.data_from_ic  = 6'($urandom);
      ia.config_commit = (i % 2 == 0);
      step();
      check("idle_to_io", 64'(ia.data_to_io), 64'(0));
      check("idle_to_ic", 64'(ia.data_to_ic), 64'(0));
      check("idle_configured", 64'(ia.configured), 64'(0));
    end
    ia.config_commit = 1'b0;

    // First load, with an early commit at 33 bits that must be ignored.
    shift_a(fa, 33, 33);
    check("a33_loaded", 64'(ia.config_loaded), 64'(0));
    commit_a();
    check("early_commit_configured", 64'(ia.configured), 64'(0));
    shift_a(fa, 0, 1);
    check("a34_loaded", 64'(ia.config_loaded), 64'(1));
    commit_a();
    check("commit_configured", 64'(ia.configured), 64'(1));
    check("commit_loaded_falls", 64'(ia.config_loaded), 64'(0));
    apply_vectors("frame_a");

    shift_a(fb, 33, 33);
    commit_a();
    check("early2_loaded", 64'(ia.config_loaded), 64'(0));
    apply_vectors("early2_keeps_a");
    shift_a(fb, 0, 1);
    check("b34_loaded", 64'(ia.config_loaded), 64'(1));

    // Commit and shift in the same cycle.
    ia.enable = 1'b0;
    ia.config_commit = 1'b1; ia.config_enable = 1'b1; ia.config_in = 1'b1;
    step();
    ia.config_commit = 1'b0; ia.config_enable = 1'b0; ia.config_in = 1'b0;
    check("cs_loaded", 64'(ia.config_loaded), 64'(0));
    ia.data_from_ic = 6'b111111; ia.data_from_io = 4'b0001;
    #1;
    check("reg_cleared", 64'(ia.data_to_io), 64'(4'b1001));
    check("frame_b_to_ic", 64'(ia.data_to_ic), 64'(6'b111111));
    step();
    check("reg_hold_disabled", 64'(ia.data_to_io), 64'(4'b1001));
    ia.enable = 1'b1;
    step();
    check("reg_load", 64'(ia.data_to_io), 64'(4'b1011));
    ia.data_from_ic = 6'b011111;
    #1;
    check("reg_not_comb", 64'(ia.data_to_io), 64'(4'b1011));
    step();
    check("reg_follow_low", 64'(ia.data_to_io), 64'(4'b1001));
    ia.enable = 1'b0; ia.data_from_ic = 6'b100000;
    #1;
    check("oor_and_comb", 64'(ia.data_to_io), 64'(4'b0000));
    step();
    check("hold_low", 64'(ia.data_to_io), 64'(4'b0000));
    ia.enable = 1'b1;
    step();
    check("reg_high_again", 64'(ia.data_to_io), 64'(4'b0010));
    ia.enable = 1'b0; ia.data_from_ic = 6'b000000;
    step();
    check("hold_high", 64'(ia.data_to_io), 64'(4'b0010));
    ia.enable = 1'b1;

    // Shifted bit during commit counted as bit 1 of the next frame.
    shift_a(fb, 33, 32);
    check("next_frame_33", 64'(ia.config_loaded), 64'(0));
    shift_a(fb, 1, 1);
    check("next_frame_34", 64'(ia.config_loaded), 64'(1));

    // Reset mid-load, dominating a concurrent shift and commit.
    do_reset();
    shift_a(fa, 33, 20);
    ia.data_from_io = 4'b1111; ia.data_from_ic = 6'b111111;
    ia.config_enable = 1'b1; ia.config_in = 1'b1; ia.config_commit = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ia.config_enable = 1'b0; ia.config_in = 1'b0; ia.config_commit = 1'b0;
    check("midrst_config_out", 64'(ia.config_out), 64'(0));
    check("midrst_loaded", 64'(ia.config_loaded), 64'(0));
    check("midrst_configured", 64'(ia.configured), 64'(0));
    check("midrst_to_io", 64'(ia.data_to_io), 64'(0));
    check("midrst_to_ic", 64'(ia.data_to_ic), 64'(0));
    shift_a(fa, 33, 33);
    check("reload33_loaded", 64'(ia.config_loaded), 64'(0));
    shift_a(fa, 0, 1);
    check("reload34_loaded", 64'(ia.config_loaded), 64'(1));
    commit_a();
    apply_vectors("reload_a");

    // Scan chain: frame c passes through tile a into tile b.
    do_reset();
    shift_a(fc, 33, 34);
    check("chain_a_out34", 64'(ia.config_out), 64'(1));
    check("chain_b_count_sat", 64'(ib.config_loaded), 64'(1));
    shift_a(34'd0, 33, 1);
    check("chain_a_out35", 64'(ia.config_out), 64'(0));
    check("chain_a_loaded_sat", 64'(ia.config_loaded), 64'(1));
    shift_a(34'd0, 32, 33);
    check("chain_b_out", 64'(ib.config_out), 64'(1));
    ib.config_commit = 1'b1;
    step();
    ib.config_commit = 1'b0;
    check("chain_b_configured", 64'(ib.configured), 64'(1));
    check("chain_a_unconfigured", 64'(ia.configured), 64'(0));
    ia.data_from_io = 4'b1000; ia.data_from_ic = 6'b100000;
    #1;
    check("chain_b_to_io", 64'(ib.data_to_io), 64'(4'b0001));
    check("chain_b_to_ic", 64'(ib.data_to_ic), 64'(6'b000100));
    step();
    check("chain_b_reg_low", 64'(ib.data_to_ic), 64'(6'b000100));
    ia.data_from_io = 4'b1010;
    #1;
    check("chain_b_reg_wait", 64'(ib.data_to_ic), 64'(6'b000100));
    step();
    check("chain_b_reg_high", 64'(ib.data_to_ic), 64'(6'b100100));
    check("chain_a_to_io_zero", 64'(ia.data_to_io), 64'(0));

    // IO_PAIRS=3 build: ISEL=3 is representable but has no source.
    shift_c(fd);
    check("c_loaded", 64'(i3.config_loaded), 64'(1));
    i3.config_commit = 1'b1;
    step();
    i3.config_commit = 1'b0;
    i3.data_from_io = 3'b111; i3.data_from_ic = 6'b111110;
    #1;
    check("c_to_io_a", 64'(i3.data_to_io), 64'(3'b000));
    check("c_to_ic_a", 64'(i3.data_to_ic), 64'(6'b111110));
    i3.data_from_io = 3'b011;
    #1;
    check("c_to_ic_b", 64'(i3.data_to_ic), 64'(6'b111100));
    i3.data_from_ic = 6'b000001;
    #1;
    check("c_to_io_b", 64'(i3.data_to_io), 64'(3'b110));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
